shadow_writer: RTL and testbench
================================

Name: shadow_writer

Overview:
- Snoops CPU write cycles to fast RAM banks $00/$01.
- Each write that falls in a shadowed video region is queued in a small FIFO, then replayed as a write into slow RAM banks $E0/$E1 at the 1 MHz slow-RAM rate.
- It is the initiator side of the slowram port: address, data and write strobe into the 128k slow RAM.
- Asserts a stall to the core when the queue is full.
- Sits in top between the core bus (bank/addr/dout/we) and the slowram instance. The slowram mux gives this block priority when sr_ce is high.

Parameters:
- DEPTH_LOG2, 3: log2 of FIFO depth (8 entries).
- ENTRY_W, 25: entry width; {bank[0], addr[15:0], data[7:0]}. Fixed; not meant to be overridden.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_ce  in  1  qualifies one CPU bus cycle (fast_clk).
- slow_ce  in  1  1 MHz enable; one drain opportunity per pulse.
- bank  in  8  CPU bank.
- addr  in  16  CPU address.
- dout  in  8  CPU write data.
- we  in  1  CPU write strobe.
- shadow  in  8  SHADOW register; bit=1 inhibits that region.
- stall  out  1  FIFO full; core must hold its cycle.
- sr_addr  out  17  slow RAM address {bank[0], addr}.
- sr_din  out  8  slow RAM write data.
- sr_we  out  1  slow RAM write strobe.
- sr_ce  out  1  slow RAM select; high for exactly one clk_sys.
- overflow  out  1  sticky: a qualifying write was dropped.
- level  out  DEPTH_LOG2+1  current FIFO occupancy.

Behaviour:
- Reset (async, reset_n=0): FIFO empty, level=0, stall=0, sr_ce=0, sr_we=0, sr_addr=0, sr_din=0, overflow=0. Takes effect immediately, including mid-drain. In-flight entries are discarded.
- Qualify (combinational): hit = cpu_ce & we & (bank==$00 | bank==$01) & region.
- Region decode (b = bank[0]):
  - text1: $0400-$07FF, enabled when shadow[0]=0.
  - text2: $0800-$0BFF, enabled when shadow[5]=0.
  - hires1: $2000-$3FFF, enabled when shadow[1]=0, and additionally (b=0 | shadow[4]=0).
  - hires2: $4000-$5FFF, enabled when shadow[2]=0, and additionally (b=0 | shadow[4]=0).
  - SHR: $2000-$9FFF, b=1 only, enabled when shadow[3]=0.
  - shadow[7:6] ignored.
- Push: on hit with level<DEPTH, or level==DEPTH with a pop in the same cycle, write {b,addr,dout} at the tail. Accepted in the same cycle.
- Drop: on hit with level==DEPTH and no pop, the write is discarded and overflow is set. overflow clears only on reset.
- Pop: on slow_ce with level>0, register the head entry onto sr_addr/sr_din and assert sr_ce=sr_we=1 for the next clk_sys cycle only. Advance the head.
- Outputs are registered, so latency from push into an empty FIFO to sr_ce is 1 cycle after the next slow_ce.
- sr_addr/sr_din hold their last value while sr_ce=0.
- Simultaneous push and pop: level unchanged, pointers both advance. An entry pushed this cycle cannot be popped this cycle.
- level: +1 on push only, -1 on pop only.
- stall = (level==DEPTH), registered from next-state level.
- Pointers are DEPTH_LOG2 bits and wrap modulo DEPTH. level disambiguates full from empty.
- Order is preserved: FIFO order equals CPU write order.
- Non-qualifying writes (outside regions, inhibited, other banks, cpu_ce=0) have no effect.

Optional Feature:
- Macro: SHADOW_COALESCE_EN.
- When defined: if hit matches the tail entry's {b,addr}, and level>=1, and that tail entry is not being popped this cycle, overwrite the tail data in place. No push, level unchanged, overflow not set even when full.
- When undefined: every hit pushes (or drops) as above.

Test Plan:
- shadow=$00, write $00:0400=$41, then slow_ce → one cycle later sr_ce=sr_we=1, sr_addr=$00400, sr_din=$41; level returns to 0.
- shadow=$01, write $00:0400=$41 → no push, level=0. Write $01:2000=$55 with shadow[3]=0 → sr_addr=$12000, sr_din=$55.
- 8 hits with no slow_ce → level=8, stall=1. A 9th hit → dropped, overflow=1. Then slow_ce → entries emerge in order, stall deasserts.
- Full FIFO; hit and slow_ce in the same cycle → hit accepted, level stays 8, overflow stays 0.
- 3 entries queued; pulse reset_n=0 between slow_ce pulses → sr_ce=0 immediately, level=0, no further slow RAM writes.
- SHADOW_COALESCE_EN: write $00:2000=$11 then $00:2000=$22 before any slow_ce → level=1, single drain with sr_din=$22. Without the macro: level=2, drains $11 then $22.

Source files
------------

// File: rtl/shadow_writer.sv
// shadow_writer: snoops CPU writes to fast RAM banks $00/$01. Writes that
// land in an enabled shadowed video region go into a small FIFO. The FIFO
// replays them into slow RAM banks $E0/$E1, one entry per 1 MHz slow_ce pulse.
//
// Optional feature: SHADOW_COALESCE_EN. When it is defined, a hit to the same
// {bank[0],addr} as the current tail entry overwrites that entry's data in
// place. This only applies when the tail entry is not being popped in the same
// cycle.
//
// Ports:
//   clk_sys   system clock, rising edge
//   reset_n   asynchronous active-low reset
//   cpu_ce    qualifies one CPU bus cycle
//   slow_ce   1 MHz drain enable
//   bank      CPU bank
//   addr      CPU address
//   dout      CPU write data
//   we        CPU write strobe
//   shadow    SHADOW register; a set bit inhibits that region
//   stall     FIFO full
//   sr_addr   slow RAM address {bank[0], addr}
//   sr_din    slow RAM write data
//   sr_we     slow RAM write strobe
//   sr_ce     slow RAM select, one clk_sys wide
//   overflow  sticky: a qualifying write was dropped
//   level     FIFO occupancy
module shadow_writer #(
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned ENTRY_W    = 25
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  cpu_ce,
  input  logic                  slow_ce,
  input  logic [7:0]            bank,
  input  logic [15:0]           addr,
  input  logic [7:0]            dout,
  input  logic                  we,
  input  logic [7:0]            shadow,
  output logic                  stall,
  output logic [16:0]           sr_addr,
  output logic [7:0]            sr_din,
  output logic                  sr_we,
  output logic                  sr_ce,
  output logic                  overflow,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned LVL_W = DEPTH_LOG2 + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] ONE_LVL  = LVL_W'(1);

  logic [ENTRY_W-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [LVL_W-1:0]      level_nxt;

  logic b;
  logic bank_ok;
  logic text1, text2, hgr1, hgr2, shr;
  logic hit;
  logic pop;
  logic push;
  logic drop;
  logic tail_hit;
  logic [ENTRY_W-1:0] entry_in;

  // Bits 7:6 of SHADOW have no meaning here.
  logic unused_shadow;
  assign unused_shadow = &{1'b0, shadow[7:6]};

  // Region decode. The hires pages in bank $01 are also gated by shadow[4].
  assign b       = bank[0];
  assign bank_ok = (bank[7:1] == 7'd0);
  assign text1   = (addr[15:10] == 6'h01) & ~shadow[0];
  assign text2   = (addr[15:10] == 6'h02) & ~shadow[5];
  assign hgr1    = (addr[15:13] == 3'h1) & ~shadow[1] & (~b | ~shadow[4]);
  assign hgr2    = (addr[15:13] == 3'h2) & ~shadow[2] & (~b | ~shadow[4]);
  assign shr     = b & (addr >= 16'h2000) & (addr <= 16'h9FFF) & ~shadow[3];
  assign hit     = cpu_ce & we & bank_ok & (text1 | text2 | hgr1 | hgr2 | shr);

  assign entry_in = {b, addr, dout};
  assign pop      = slow_ce & (level != '0);

`ifdef SHADOW_COALESCE_EN
  logic [DEPTH_LOG2-1:0] tail_ptr;
  assign tail_ptr = wr_ptr - DEPTH_LOG2'(1);
  // Merge into the tail only if that entry is not leaving the FIFO this cycle.
  assign tail_hit = hit & (level != '0)
                  & (mem[tail_ptr][ENTRY_W-1:8] == {b, addr})
                  & ~(pop & (level == ONE_LVL));
`else
  assign tail_hit = 1'b0;
`endif

  // A full FIFO still accepts a write when a pop frees a slot in the same cycle.
  assign push = hit & ~tail_hit & ((level != FULL_LVL) | pop);
  assign drop = hit & ~tail_hit & (level == FULL_LVL) & ~pop;

  // Next occupancy.
  always_comb begin
    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + ONE_LVL;
      2'b01:   level_nxt = level - ONE_LVL;
      default: level_nxt = level;
    endcase
  end

  // FIFO storage. It has no reset; level and the pointers define validity.
  always_ff @(posedge clk_sys) begin
    if (push) begin
      mem[wr_ptr] <= entry_in;
    end
`ifdef SHADOW_COALESCE_EN
    else if (tail_hit) begin
      mem[tail_ptr][7:0] <= dout;
    end
`endif
  end

  // Pointers, occupancy, flags and the registered slow RAM port.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      stall    <= 1'b0;
      overflow <= 1'b0;
      sr_ce    <= 1'b0;
      sr_we    <= 1'b0;
      sr_addr  <= '0;
      sr_din   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      level    <= level_nxt;
      stall    <= (level_nxt == FULL_LVL);
      if (drop) overflow <= 1'b1;
      sr_ce    <= pop;
      sr_we    <= pop;
      if (pop) begin
        sr_addr <= mem[rd_ptr][ENTRY_W-1:8];
        sr_din  <= mem[rd_ptr][7:0];
      end
    end
  end

endmodule

// File: tb/tb_shadow_writer.sv
// Directed and randomized bench for shadow_writer. A queue-based reference
// model supplies the expected value for every output after every clock.
module tb_shadow_writer;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        cpu_ce;
  logic        slow_ce;
  logic [7:0]  bank;
  logic [15:0] addr;
  logic [7:0]  dout;
  logic        we;
  logic [7:0]  shadow;
  logic        stall;
  logic [16:0] sr_addr;
  logic [7:0]  sr_din;
  logic        sr_we;
  logic        sr_ce;
  logic        overflow;
  logic [3:0]  level;

  shadow_writer dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .cpu_ce   (cpu_ce),
    .slow_ce  (slow_ce),
    .bank     (bank),
    .addr     (addr),
    .dout     (dout),
    .we       (we),
    .shadow   (shadow),
    .stall    (stall),
    .sr_addr  (sr_addr),
    .sr_din   (sr_din),
    .sr_we    (sr_we),
    .sr_ce    (sr_ce),
    .overflow (overflow),
    .level    (level)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [24:0] mq[$];
  bit          m_ovf;
  bit          m_ce;
  logic [16:0] m_addr;
  logic [7:0]  m_din;

  function automatic bit region_hit(input bit b, input int a, input logic [7:0] sh);
    bit r;
    r = 1'b0;
    if (a >= 'h0400 && a <= 'h07FF && !sh[0]) r = 1'b1;
    if (a >= 'h0800 && a <= 'h0BFF && !sh[5]) r = 1'b1;
    if (a >= 'h2000 && a <= 'h3FFF && !sh[1] && (!b || !sh[4])) r = 1'b1;
    if (a >= 'h4000 && a <= 'h5FFF && !sh[2] && (!b || !sh[4])) r = 1'b1;
    if (b && a >= 'h2000 && a <= 'h9FFF && !sh[3]) r = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ovf  = 1'b0;
    m_ce   = 1'b0;
    m_addr = '0;
    m_din  = '0;
  endtask

  // One clock of model behaviour, using the inputs that were present at the edge.
  task automatic model_step();
    bit h, p, coal;
    logic [16:0] key;
    logic [24:0] tmp;
    h    = cpu_ce && we && (bank == 8'h00 || bank == 8'h01) &&
           region_hit(bank[0], int'(addr), shadow);
    p    = slow_ce && (mq.size() > 0);
    key  = {bank[0], addr};
    coal = 1'b0;
`ifdef SHADOW_COALESCE_EN
    if (h && mq.size() >= 1 && mq[mq.size()-1][24:8] == key && !(p && mq.size() == 1))
      coal = 1'b1;
`endif
    if (coal) begin
      tmp = mq[mq.size()-1];
      tmp[7:0] = dout;
      mq[mq.size()-1] = tmp;
    end
    m_ce = p;
    if (p) begin
      {m_addr, m_din} = mq[0];
      void'(mq.pop_front());
    end
    if (h && !coal) begin
      if (mq.size() < 8) mq.push_back({key, dout});
      else m_ovf = 1'b1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".level"},    32'(level),    32'(mq.size()));
    check({tag, ".stall"},    32'(stall),    32'(mq.size() == 8));
    check({tag, ".sr_ce"},    32'(sr_ce),    32'(m_ce));
    check({tag, ".sr_we"},    32'(sr_we),    32'(m_ce));
    check({tag, ".sr_addr"},  32'(sr_addr),  32'(m_addr));
    check({tag, ".sr_din"},   32'(sr_din),   32'(m_din));
    check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
  endtask

  // Drive one cycle of inputs, clock it, update the model, then sample.
  task automatic cyc(input logic ce, input logic w, input logic sl,
                     input logic [7:0] bk, input logic [15:0] ad, input logic [7:0] d,
                     input string tag);
    cpu_ce  = ce;
    we      = w;
    slow_ce = sl;
    bank    = bk;
    addr    = ad;
    dout    = d;
    @(posedge clk_sys);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 8'h00, tag);
  endtask

  task automatic drain(input string tag);
    cyc(1'b0, 1'b0, 1'b1, 8'h00, 16'h0000, 8'h00, tag);
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    @(posedge clk_sys);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    cpu_ce  = 1'b0;
    slow_ce = 1'b0;
    bank    = '0;
    addr    = '0;
    dout    = '0;
    we      = 1'b0;
    shadow  = 8'h00;
    model_reset();
    #2;
    check_all("reset");
    @(posedge clk_sys);
    #1;
    reset_n = 1'b1;

    // A single text page write travels to slow RAM.
    cyc(1'b1, 1'b1, 1'b0, 8'h00, 16'h0400, 8'h41, "t1_push");
    check("t1_level", 32'(level), 32'd1);
    idle("t1_idle");
    drain("t1_pop");
    check("t1_ce",   32'(sr_ce),   32'd1);
    check("t1_addr", 32'(sr_addr), 32'h00400);
    check("t1_din",  32'(sr_din),  32'h41);
    check("t1_lvl0", 32'(level),   32'd0);
    idle("t1_after");
    check("t1_ce_low", 32'(sr_ce), 32'd0);

    // Inhibited text page, then a super hires write in bank $01.
    shadow = 8'h01;
    cyc(1'b1, 1'b1, 1'b0, 8'h00, 16'h0400, 8'h41, "t2_inhib");
    check("t2_nopush", 32'(level), 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 8'h01, 16'h2000, 8'h55, "t2_shr");
    drain("t2_pop");
    check("t2_addr", 32'(sr_addr), 32'h12000);
    check("t2_din",  32'(sr_din),  32'h55);
    shadow = 8'h00;

    // Fill the FIFO, overflow it, then drain it in order.
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 1'b1, 1'b0, 8'h00, 16'h2000 + 16'(i), 8'(8'h10 + i), "t3_fill");
    check("t3_full_lvl",   32'(level), 32'd8);
    check("t3_full_stall", 32'(stall), 32'd1);
    cyc(1'b1, 1'b1, 1'b0, 8'h00, 16'h2100, 8'hEE, "t3_drop");
    check("t3_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 8; i++) begin
      drain("t3_drain");
      check("t3_order", 32'(sr_din), 32'(8'h10 + i));
      if (i == 0) check("t3_unstall", 32'(stall), 32'd0);
    end

    // Full FIFO with a hit and a pop in the same cycle.
    do_reset("t4_reset");
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 1'b1, 1'b0, 8'h00, 16'h4000 + 16'(i), 8'(8'h20 + i), "t4_fill");
    cyc(1'b1, 1'b1, 1'b1, 8'h00, 16'h4100, 8'h99, "t4_pushpop");
    check("t4_lvl", 32'(level),    32'd8);
    check("t4_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) drain("t4_drain");
    check("t4_last", 32'(sr_din), 32'h99);

    // Reset in the middle of a drain discards everything.
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'b1, 1'b0, 8'h00, 16'h0800 + 16'(i), 8'(8'h30 + i), "t5_fill");
    drain("t5_pop");
    check("t5_ce_hi", 32'(sr_ce), 32'd1);
    do_reset("t5_reset");
    check("t5_ce_lo", 32'(sr_ce), 32'd0);
    check("t5_lvl",   32'(level), 32'd0);
    for (int i = 0; i < 3; i++) drain("t5_quiet");

    // Repeated write to one address before any drain.
    cyc(1'b1, 1'b1, 1'b0, 8'h00, 16'h2000, 8'h11, "t6_w1");
    cyc(1'b1, 1'b1, 1'b0, 8'h00, 16'h2000, 8'h22, "t6_w2");
`ifdef SHADOW_COALESCE_EN
    check("t6_lvl", 32'(level), 32'd1);
    drain("t6_pop");
    check("t6_din", 32'(sr_din), 32'h22);
`else
    check("t6_lvl", 32'(level), 32'd2);
    drain("t6_pop1");
    check("t6_din1", 32'(sr_din), 32'h11);
    drain("t6_pop2");
    check("t6_din2", 32'(sr_din), 32'h22);
`endif
    idle("t6_idle");

    // Randomized traffic with varying drain rates.
    begin
      logic [7:0]  rb, pb;
      logic [15:0] ra, pa;
      int          sel, drain_pct;
      pb = 8'h00;
      pa = 16'h2000;
      for (int i = 0; i < 3000; i++) begin
        if (i % 500 == 0) begin
          drain_pct = (i / 500) * 12 + 5;
          shadow = 8'($urandom);
        end
        sel = int'($urandom_range(0, 7));
        rb = (sel < 3) ? 8'h00 : (sel < 6) ? 8'h01 : (sel == 6) ? 8'hE0 : 8'($urandom);
        case ($urandom_range(0, 5))
          0: ra = 16'h0400 + 16'($urandom_range(0, 'h7FF));
          1: ra = 16'h2000 + 16'($urandom_range(0, 'h3FFF));
          2: ra = 16'h6000 + 16'($urandom_range(0, 'h3FFF));
          3: ra = 16'($urandom);
          default: begin ra = pa; rb = pb; end
        endcase
        pa = ra;
        pb = rb;
        cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
            1'(int'($urandom_range(0, 99)) < drain_pct), rb, ra, 8'($urandom), "rand");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
